// File: rtl/dmem_pkg.sv
// Shared encodings, widths and bus payload type for the data-memory access unit.
package dmem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned OFF_W  = 2;

    localparam logic [SIZE_W-1:0] MEM_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] MEM_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] MEM_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT0 = 3'd1,
        REQ1  = 3'd2,
        WAIT1 = 3'd3,
        DONE  = 3'd4
    } dmem_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } dmem_tx_t;

    // Unshifted byte-enable pattern for an access size; 2'b11 behaves as a word.
    function automatic logic [BE_W-1:0] size_base_mask(input logic [SIZE_W-1:0] size);
        case (size)
            MEM_BYTE: return BE_W'(4'b0001);
            MEM_HALF: return BE_W'(4'b0011);
            default:  return BE_W'(4'b1111);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory request/grant/rvalid bus between the access unit and the memory.
interface dmem_access_unit_if;
    import dmem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: enable mask over two words, split detect,
// store-data lane shift and load-data right-justification.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [SIZE_W-1:0]   size,
    input  logic [OFF_W-1:0]    off,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [2*DATA_W-1:0] rdata_pair,
    output logic [2*BE_W-1:0]   be_pair,
    output logic                split,
    output logic [2*DATA_W-1:0] wdata_pair,
    output logic [DATA_W-1:0]   rdata_aligned
);

    logic [OFF_W+2:0] lane_shift;

    always_comb begin
        lane_shift    = {off, 3'b000};
        be_pair       = {{BE_W{1'b0}}, size_base_mask(size)} << off;
        split         = |be_pair[2*BE_W-1:BE_W];
        wdata_pair    = {{DATA_W{1'b0}}, wdata} << lane_shift;
        rdata_aligned = DATA_W'(rdata_pair >> lane_shift);
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: issues one or two word-aligned bus
// transactions per access, stalls the pipeline meanwhile, returns load data.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Mi_memRead,
    input  logic                Mi_memWrite,
    input  logic [SIZE_W-1:0]   Mi_memSize,
    input  logic [ADDR_W-1:0]   Mi_addr,
    input  logic [DATA_W-1:0]   Mi_writeData,
    output logic [DATA_W-1:0]   Mo_readData,
    output logic                Mo_memStall,
    output logic                Mo_misaligned,
    dmem_access_unit_if.master  dmem
);

    dmem_state_e       state_q, state_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    logic                acc;
    logic                is_load;
    logic                split;
    logic                issue;
    logic [2*BE_W-1:0]   be_pair;
    logic [2*DATA_W-1:0] wdata_pair;
    logic [2*DATA_W-1:0] rdata_pair;
    logic [DATA_W-1:0]   rdata_aligned;
    dmem_tx_t            tx0, tx1, tx_c;
    logic                req_c;
    logic                stall_c;

    assign acc     = Mi_memRead | Mi_memWrite;
    assign is_load = Mi_memRead & ~Mi_memWrite;
    assign issue   = acc & ~(split & ~SPLIT_MISALIGNED);

    // Second-word data is only meaningful in WAIT1; otherwise the high word reads as zero.
    assign rdata_pair = (state_q == WAIT1) ? {dmem.rdata, r0_q}
                                           : {{DATA_W{1'b0}}, dmem.rdata};

    dmem_lane_align u_lane_align (
        .size          (Mi_memSize),
        .off           (Mi_addr[OFF_W-1:0]),
        .wdata         (Mi_writeData),
        .rdata_pair    (rdata_pair),
        .be_pair       (be_pair),
        .split         (split),
        .wdata_pair    (wdata_pair),
        .rdata_aligned (rdata_aligned)
    );

    // Both transaction payloads; the pipeline holds its inputs stable while stalled.
    always_comb begin
        tx0.addr  = {Mi_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        tx0.be    = be_pair[BE_W-1:0];
        tx0.wdata = wdata_pair[DATA_W-1:0];
        tx1.addr  = tx0.addr + ADDR_W'(BE_W);
        tx1.be    = be_pair[2*BE_W-1:BE_W];
        tx1.wdata = wdata_pair[2*DATA_W-1:DATA_W];
    end

    // Next-state, captures and bus/stall decode.
    always_comb begin
        state_d     = state_q;
        r0_d        = r0_q;
        read_data_d = read_data_q;
        req_c       = 1'b0;
        stall_c     = 1'b0;
        tx_c        = tx0;

        case (state_q)
            IDLE: begin
                req_c   = issue;
                stall_c = issue;
                if (issue && dmem.gnt) begin
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                stall_c = 1'b1;
                if (dmem.rvalid) begin
                    r0_d = dmem.rdata;
                    if (split) begin
                        state_d = REQ1;
                    end else begin
                        state_d = DONE;
                        if (is_load) begin
                            read_data_d = rdata_aligned;
                        end
                    end
                end
            end
            REQ1: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                tx_c    = tx1;
                if (dmem.gnt) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                stall_c = 1'b1;
                tx_c    = tx1;
                if (dmem.rvalid) begin
                    state_d = DONE;
                    if (is_load) begin
                        read_data_d = rdata_aligned;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r0_q        <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            r0_q        <= r0_d;
            read_data_q <= read_data_d;
        end
    end

    assign dmem.req      = req_c;
    assign dmem.we       = Mi_memWrite;
    assign dmem.addr     = tx_c.addr;
    assign dmem.be       = tx_c.be;
    assign dmem.wdata    = tx_c.wdata;

    assign Mo_readData   = read_data_q;
    assign Mo_memStall   = stall_c;
    assign Mo_misaligned = acc & split & ~SPLIT_MISALIGNED;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a bus responder checks each request
// against a queue of expected transactions; load results come from a second queue.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] read_data;
    logic        stall, misaligned;

    logic        mem_read2, mem_write2;
    logic [1:0]  mem_size2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [31:0] read_data2;
    logic        stall2, misaligned2;

    dmem_access_unit_if bus ();
    dmem_access_unit_if bus2 ();

    dmem_access_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .Mi_memRead   (mem_read),
        .Mi_memWrite  (mem_write),
        .Mi_memSize   (mem_size),
        .Mi_addr      (mem_addr),
        .Mi_writeData (mem_wdata),
        .Mo_readData  (read_data),
        .Mo_memStall  (stall),
        .Mo_misaligned(misaligned),
        .dmem         (bus)
    );

    dmem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk          (clk),
        .reset        (reset),
        .Mi_memRead   (mem_read2),
        .Mi_memWrite  (mem_write2),
        .Mi_memSize   (mem_size2),
        .Mi_addr      (mem_addr2),
        .Mi_writeData (mem_wdata2),
        .Mo_readData  (read_data2),
        .Mo_memStall  (stall2),
        .Mo_misaligned(misaligned2),
        .dmem         (bus2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_tx_t;

    exp_tx_t     exp_tx_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] model_rd;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tx(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        exp_tx_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        exp_tx_q.push_back(t);
    endtask

    // Drive one access from IDLE, act as the memory, and check bus, stall and result.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gnt_wait, input int rv_wait,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input int exp_stall, input logic [31:0] exp_load);
        int      stall_cnt = 0;
        int      txn = 0;
        int      held = 0;
        int      rv_cnt = 0;
        int      cycles = 0;
        bit      finished = 1'b0;
        exp_tx_t head;
        mem_read = rd; mem_write = wr; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        if (rd && !wr) model_rd = exp_load;
        exp_rd_q.push_back(model_rd);
        while (!finished && cycles < 40) begin
            #1;
            bus.gnt = 1'b0;
            bus.rvalid = 1'b0;
            if (rv_cnt == 1) begin
                bus.rvalid = 1'b1;
                bus.rdata  = (txn == 1) ? rd0 : rd1;
            end
            if (rv_cnt > 0) rv_cnt--;
            if (bus.req === 1'b1) begin
                if (exp_tx_q.size() == 0) begin
                    check("unexpected_req", 32'(bus.req), 32'd0);
                end else begin
                    head = exp_tx_q[0];
                    check("tx_we",    32'(bus.we), 32'(head.we));
                    check("tx_addr",  bus.addr,    head.addr);
                    check("tx_be",    32'(bus.be), 32'(head.be));
                    check("tx_wdata", bus.wdata,   head.wdata);
                    if (held < gnt_wait) begin
                        held++;
                    end else begin
                        bus.gnt = 1'b1;
                        void'(exp_tx_q.pop_front());
                        txn++;
                        held = 0;
                        rv_cnt = rv_wait;
                    end
                end
            end
            #1;
            if (cycles == 0) check("misaligned_low", 32'(misaligned), 32'd0);
            if (stall === 1'b1) stall_cnt++;
            else if (txn > 0) finished = 1'b1;
            if (finished) begin
                check("done_no_req",  32'(bus.req),   32'd0);
                check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
                check("all_tx_issued", 32'(exp_tx_q.size()), 32'd0);
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            tick();
            cycles++;
        end
        check("done_in_budget", 32'(finished), 32'd1);
        mem_read = 1'b0;
        mem_write = 1'b0;
        exp_tx_q.delete();
        #1;
        check("read_data", read_data, exp_rd_q.pop_front());
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10; mem_addr = '0; mem_wdata = '0;
        mem_read2 = 1'b0; mem_write2 = 1'b0; mem_size2 = 2'b10; mem_addr2 = '0; mem_wdata2 = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus2.gnt = 1'b0; bus2.rvalid = 1'b0; bus2.rdata = '0;
        model_rd = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_read_data",  read_data,           32'd0);
        check("rst_stall",      32'(stall),          32'd0);
        check("rst_req",        32'(bus.req),        32'd0);
        check("rst_misaligned", 32'(misaligned),     32'd0);
        check("rst_read_data2", read_data2,          32'd0);

        // Aligned word load.
        expect_tx(1'b0, 32'h0000_1000, 4'b1111, 32'h0);
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 0, 1,
                   32'hDEAD_BEEF, 32'h0, 2, 32'hDEAD_BEEF);

        // Byte store to top lane; load data untouched.
        expect_tx(1'b1, 32'h0000_2000, 4'b1000, 32'hA500_0000);
        run_access(1'b0, 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 0, 1,
                   32'h0, 32'h0, 2, 32'h0);

        // Word load crossing a word boundary.
        expect_tx(1'b0, 32'h0000_3000, 4'b1100, 32'h0);
        expect_tx(1'b0, 32'h0000_3004, 4'b0011, 32'h0);
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_3002, 32'h0, 0, 1,
                   32'h4433_2211, 32'h8877_6655, 4, 32'h6655_4433);

        // Half store crossing a word boundary with a carry into bit 24.
        expect_tx(1'b1, 32'h40FF_FFFC, 4'b1000, 32'hAA00_0000);
        expect_tx(1'b1, 32'h4100_0000, 4'b0001, 32'h0000_00BB);
        run_access(1'b0, 1'b1, 2'b01, 32'h40FF_FFFF, 32'h0000_BBAA, 0, 1,
                   32'h0, 32'h0, 4, 32'h0);

        // Grant withheld 3 cycles, rvalid 2 cycles after acceptance.
        expect_tx(1'b0, 32'h0000_6004, 4'b1111, 32'h0);
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_6004, 32'h0, 3, 2,
                   32'h1234_5678, 32'h0, 6, 32'h1234_5678);

        // Aligned half and byte loads: upper bytes pass through unmasked.
        expect_tx(1'b0, 32'h0000_7000, 4'b1100, 32'h0);
        run_access(1'b1, 1'b0, 2'b01, 32'h0000_7002, 32'h0, 0, 1,
                   32'hCAFE_F00D, 32'h0, 2, 32'h0000_CAFE);
        expect_tx(1'b0, 32'h0000_8000, 4'b0010, 32'h0);
        run_access(1'b1, 1'b0, 2'b00, 32'h0000_8001, 32'h0, 0, 1,
                   32'h1122_3344, 32'h0, 2, 32'h0011_2233);

        // Size 2'b11 behaves as a word; both strobes high means store.
        expect_tx(1'b0, 32'h0000_9000, 4'b1111, 32'h0);
        run_access(1'b1, 1'b0, 2'b11, 32'h0000_9000, 32'h0, 0, 1,
                   32'h55AA_55AA, 32'h0, 2, 32'h55AA_55AA);
        expect_tx(1'b1, 32'h0000_9100, 4'b0011, 32'h0000_7766);
        run_access(1'b1, 1'b1, 2'b01, 32'h0000_9100, 32'h0000_7766, 0, 1,
                   32'hFFFF_FFFF, 32'h0, 2, 32'h0);

        // Reset while waiting for rvalid, then a stray rvalid in IDLE.
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_A000;
        #1;
        check("rst_mid_req", 32'(bus.req), 32'd1);
        bus.gnt = 1'b1;
        tick();
        bus.gnt = 1'b0;
        #1;
        check("rst_mid_wait_stall", 32'(stall),   32'd1);
        check("rst_mid_wait_req",   32'(bus.req), 32'd0);
        reset = 1'b1;
        mem_read = 1'b0;
        tick();
        reset = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'hFFFF_FFFF;
        #1;
        check("stray_rv_stall", 32'(stall),   32'd0);
        check("stray_rv_req",   32'(bus.req), 32'd0);
        tick();
        bus.rvalid = 1'b0;
        #1;
        check("stray_rv_read_data", read_data, 32'd0);
        model_rd = '0;

        // Normal operation after the abandoned access.
        expect_tx(1'b0, 32'h0000_B000, 4'b1111, 32'h0);
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_B000, 32'h0, 0, 1,
                   32'h0BAD_F00D, 32'h0, 2, 32'h0BAD_F00D);

        // Non-splitting instance: word-crossing access is flagged, never issued.
        mem_read2 = 1'b1; mem_size2 = 2'b10; mem_addr2 = 32'h0000_5001;
        #1;
        check("nosplit_misaligned", 32'(misaligned2), 32'd1);
        check("nosplit_req",        32'(bus2.req),    32'd0);
        check("nosplit_stall",      32'(stall2),      32'd0);
        tick();
        check("nosplit_req_hold",   32'(bus2.req),    32'd0);
        check("nosplit_read_data",  read_data2,       32'd0);
        mem_size2 = 2'b01; mem_addr2 = 32'h0000_5002;
        #1;
        check("nosplit_half_ok",    32'(misaligned2), 32'd0);
        check("nosplit_half_req",   32'(bus2.req),    32'd1);
        mem_read2 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
